// File: rtl/regbank_sequencer.sv
// regbank_sequencer
//   Owns the write port of the 37-entry banked register file. It arbitrates
//   between pipeline writeback and exception entry, and maps logical
//   registers r0-r15 plus the processor mode onto physical bank indices.
//   An accepted exception runs a four-cycle entry sequence:
//   SPSR save, LR write, CPSR update, PC load.
// Ports
//   clk1, rst                : clock, synchronous active-high reset
//   cur_mode, cpsr_in        : current CPSR mode field and full CPSR
//   rd_lreg1/2 -> rd_paddr1/2: combinational read-side mapping
//   wb_req/wb_lreg/wb_data   : writeback request; wb_ack accepts it
//   exc_req/exc_type/exc_ret : exception request; exc_ack accepts it
//   exc_done                 : pulses during the PC-write cycle
//   bank_w/bank_paddr/bank_wdata, pc_w/pc_wdata,
//   cpsr_w/cpsr_wdata/cpsr_mask : registered write strobes and data
module regbank_sequencer #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
  parameter int          PADDR_W     = 6
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic [4:0]         cur_mode,
  input  logic [31:0]        cpsr_in,
  input  logic [3:0]         rd_lreg1,
  input  logic [3:0]         rd_lreg2,
  output logic [PADDR_W-1:0] rd_paddr1,
  output logic [PADDR_W-1:0] rd_paddr2,
  input  logic               wb_req,
  input  logic [3:0]         wb_lreg,
  input  logic [31:0]        wb_data,
  output logic               wb_ack,
  input  logic               exc_req,
  input  logic [2:0]         exc_type,
  input  logic [31:0]        exc_ret,
  output logic               exc_ack,
  output logic               exc_done,
  output logic               bank_w,
  output logic [PADDR_W-1:0] bank_paddr,
  output logic [31:0]        bank_wdata,
  output logic               pc_w,
  output logic [31:0]        pc_wdata,
  output logic               cpsr_w,
  output logic [31:0]        cpsr_wdata,
  output logic [31:0]        cpsr_mask
);

  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;

  typedef enum logic [2:0] {IDLE, WB, E_SPSR, E_LR, E_CPSR, E_PC} state_t;

  state_t      state;
  logic [2:0]  exc_type_q;
  logic [31:0] exc_ret_q;
  logic        cpsr_f_q;   // only the F bit of the old CPSR is needed after accept

  // logical register + mode -> physical bank index
  function automatic logic [5:0] map_reg(input logic [4:0] mode, input logic [3:0] lr);
    logic [5:0] p;
    p = {2'b00, lr};
    case (mode)
      M_FIQ: if (lr >= 4'd8 && lr <= 4'd14) p = {2'b00, lr} + 6'd8;
      M_SVC: if (lr == 4'd13) p = 6'd23; else if (lr == 4'd14) p = 6'd24;
      M_ABT: if (lr == 4'd13) p = 6'd25; else if (lr == 4'd14) p = 6'd26;
      M_IRQ: if (lr == 4'd13) p = 6'd27; else if (lr == 4'd14) p = 6'd28;
      M_UND: if (lr == 4'd13) p = 6'd29; else if (lr == 4'd14) p = 6'd30;
      default: p = {2'b00, lr};
    endcase
    return p;
  endfunction

  function automatic logic [5:0] spsr_idx(input logic [4:0] mode);
    case (mode)
      M_FIQ:   return 6'd32;
      M_SVC:   return 6'd33;
      M_ABT:   return 6'd34;
      M_IRQ:   return 6'd35;
      default: return 6'd36;  // und; only reachable target modes are passed in
    endcase
  endfunction

  function automatic logic [4:0] tgt_mode(input logic [2:0] t);
    case (t)
      3'd1:      return M_UND;
      3'd3, 3'd4: return M_ABT;
      3'd5:      return M_IRQ;
      3'd6:      return M_FIQ;
      default:   return M_SVC;  // reset, swi
    endcase
  endfunction

  function automatic logic [31:0] vec_off(input logic [2:0] t);
    case (t)
      3'd1:    return 32'h04;
      3'd2:    return 32'h08;
      3'd3:    return 32'h0C;
      3'd4:    return 32'h10;
      3'd5:    return 32'h18;
      3'd6:    return 32'h1C;
      default: return 32'h00;
    endcase
  endfunction

  assign rd_paddr1 = PADDR_W'(map_reg(cur_mode, rd_lreg1));
  assign rd_paddr2 = PADDR_W'(map_reg(cur_mode, rd_lreg2));

  // Acks are the only combinational outputs; type 7 is treated as no request.
  logic can_accept;
  assign can_accept = (state == IDLE) || (state == WB);
  assign exc_ack    = !rst && can_accept && exc_req && (exc_type != 3'd7);
  assign wb_ack     = !rst && can_accept && !exc_ack && wb_req;

  // Strobes for a state are registered on the edge that enters that state.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      exc_type_q <= 3'd0;
      exc_ret_q  <= 32'h0;
      cpsr_f_q   <= 1'b0;
      bank_w     <= 1'b0;
      pc_w       <= 1'b0;
      cpsr_w     <= 1'b0;
      exc_done   <= 1'b0;
      bank_paddr <= '0;
      bank_wdata <= 32'h0;
      pc_wdata   <= 32'h0;
      cpsr_wdata <= 32'h0;
      cpsr_mask  <= 32'h0;
    end else begin
      bank_w   <= 1'b0;
      pc_w     <= 1'b0;
      cpsr_w   <= 1'b0;
      exc_done <= 1'b0;
      case (state)
        IDLE, WB: begin
          if (exc_ack) begin
            state      <= E_SPSR;
            exc_type_q <= exc_type;
            exc_ret_q  <= exc_ret;
            cpsr_f_q   <= cpsr_in[6];
            bank_w     <= 1'b1;
            bank_paddr <= PADDR_W'(spsr_idx(tgt_mode(exc_type)));
            bank_wdata <= cpsr_in;
          end else if (wb_ack) begin
            state <= WB;
            if (wb_lreg == 4'd15) begin
              pc_w     <= 1'b1;
              pc_wdata <= wb_data;
            end else begin
              bank_w     <= 1'b1;
              bank_paddr <= PADDR_W'(map_reg(cur_mode, wb_lreg));
              bank_wdata <= wb_data;
            end
          end else begin
            state <= IDLE;
          end
        end
        E_SPSR: begin
          state      <= E_LR;
          bank_w     <= 1'b1;
          bank_paddr <= PADDR_W'(map_reg(tgt_mode(exc_type_q), 4'd14));
          bank_wdata <= exc_ret_q;
        end
        E_LR: begin
          state      <= E_CPSR;
          cpsr_w     <= 1'b1;
          cpsr_mask  <= 32'h0000_00FF;
          // I=1, T=0; F forced for reset/fiq, otherwise preserved
          cpsr_wdata <= {24'h0, 1'b1,
                         ((exc_type_q == 3'd0) || (exc_type_q == 3'd6)) ? 1'b1 : cpsr_f_q,
                         1'b0, tgt_mode(exc_type_q)};
        end
        E_CPSR: begin
          state    <= E_PC;
          pc_w     <= 1'b1;
          pc_wdata <= VECTOR_BASE + vec_off(exc_type_q);
          exc_done <= 1'b1;
        end
        default: state <= IDLE;  // E_PC
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_sequencer.sv
module tb_regbank_sequencer;
  logic clk1 = 1'b0;
  logic rst;
  logic [4:0]  cur_mode;
  logic [31:0] cpsr_in;
  logic [3:0]  rd_lreg1, rd_lreg2;
  logic [5:0]  rd_paddr1, rd_paddr2;
  logic        wb_req;
  logic [3:0]  wb_lreg;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        exc_req;
  logic [2:0]  exc_type;
  logic [31:0] exc_ret;
  logic        exc_ack, exc_done, bank_w, pc_w, cpsr_w;
  logic [5:0]  bank_paddr;
  logic [31:0] bank_wdata, pc_wdata, cpsr_wdata, cpsr_mask;
  // second instance with a high vector base, driven identically
  logic [5:0]  h_rd_paddr1, h_rd_paddr2, h_bank_paddr;
  logic        h_wb_ack, h_exc_ack, h_exc_done, h_bank_w, h_pc_w, h_cpsr_w;
  logic [31:0] h_bank_wdata, h_pc_wdata, h_cpsr_wdata, h_cpsr_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk1 = ~clk1;

  regbank_sequencer dut (
    .clk1(clk1), .rst(rst), .cur_mode(cur_mode), .cpsr_in(cpsr_in),
    .rd_lreg1(rd_lreg1), .rd_lreg2(rd_lreg2), .rd_paddr1(rd_paddr1), .rd_paddr2(rd_paddr2),
    .wb_req(wb_req), .wb_lreg(wb_lreg), .wb_data(wb_data), .wb_ack(wb_ack),
    .exc_req(exc_req), .exc_type(exc_type), .exc_ret(exc_ret), .exc_ack(exc_ack),
    .exc_done(exc_done), .bank_w(bank_w), .bank_paddr(bank_paddr), .bank_wdata(bank_wdata),
    .pc_w(pc_w), .pc_wdata(pc_wdata), .cpsr_w(cpsr_w), .cpsr_wdata(cpsr_wdata),
    .cpsr_mask(cpsr_mask)
  );

  regbank_sequencer #(.VECTOR_BASE(32'hFFFF_0000), .PADDR_W(6)) dut_hi (
    .clk1(clk1), .rst(rst), .cur_mode(cur_mode), .cpsr_in(cpsr_in),
    .rd_lreg1(rd_lreg1), .rd_lreg2(rd_lreg2), .rd_paddr1(h_rd_paddr1), .rd_paddr2(h_rd_paddr2),
    .wb_req(wb_req), .wb_lreg(wb_lreg), .wb_data(wb_data), .wb_ack(h_wb_ack),
    .exc_req(exc_req), .exc_type(exc_type), .exc_ret(exc_ret), .exc_ack(h_exc_ack),
    .exc_done(h_exc_done), .bank_w(h_bank_w), .bank_paddr(h_bank_paddr), .bank_wdata(h_bank_wdata),
    .pc_w(h_pc_w), .pc_wdata(h_pc_wdata), .cpsr_w(h_cpsr_w), .cpsr_wdata(h_cpsr_wdata),
    .cpsr_mask(h_cpsr_mask)
  );

  // {bank_w, pc_w, cpsr_w, exc_done, wb_ack, exc_ack}
  logic [5:0] ctl;
  assign ctl = {bank_w, pc_w, cpsr_w, exc_done, wb_ack, exc_ack};

  task automatic step;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    tests++;
    if (ctl !== 6'b0) begin fails++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b0); end
    tests++;
    if ({bank_paddr, bank_wdata, pc_wdata, cpsr_wdata, cpsr_mask} !== 134'h0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%h/%h exp 0", bank_paddr, bank_wdata, pc_wdata, cpsr_wdata, cpsr_mask);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (ctl !== 6'b0) begin fails++; $display("FAIL idle_ctl[%0d] got %b exp %b", i, ctl, 6'b0); end
    end
  endtask

  task automatic test_read_map;
    cur_mode = 5'b10001; rd_lreg1 = 4'd8; rd_lreg2 = 4'd15;
    #1;
    tests++;
    if ({rd_paddr1, rd_paddr2} !== {6'd16, 6'd15}) begin
      fails++; $display("FAIL rd_map_fiq got %0d/%0d exp 16/15", rd_paddr1, rd_paddr2);
    end
    cur_mode = 5'b10111; rd_lreg1 = 4'd13; rd_lreg2 = 4'd8;
    #1;
    tests++;
    if ({rd_paddr1, rd_paddr2} !== {6'd25, 6'd8}) begin
      fails++; $display("FAIL rd_map_abt got %0d/%0d exp 25/8", rd_paddr1, rd_paddr2);
    end
    cur_mode = 5'b00101; rd_lreg1 = 4'd14; rd_lreg2 = 4'd13;
    #1;
    tests++;
    if ({rd_paddr1, rd_paddr2} !== {6'd14, 6'd13}) begin
      fails++; $display("FAIL rd_map_undef got %0d/%0d exp 14/13", rd_paddr1, rd_paddr2);
    end
  endtask

  task automatic test_wb_irq;
    cur_mode = 5'b10010; wb_req = 1'b1; wb_lreg = 4'd13; wb_data = 32'hDEAD_BEEF;
    #1;
    tests++;
    if ({wb_ack, exc_ack} !== 2'b10) begin fails++; $display("FAIL wb_irq_ack got %b exp 10", {wb_ack, exc_ack}); end
    step();
    wb_req = 1'b0;
    tests++;
    if ({bank_w, pc_w, bank_paddr, bank_wdata} !== {1'b1, 1'b0, 6'd27, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL wb_irq_write got w=%b pc=%b a=%0d d=%h exp w=1 pc=0 a=27 d=deadbeef", bank_w, pc_w, bank_paddr, bank_wdata);
    end
    step();
  endtask

  task automatic test_back_to_back;
    cur_mode = 5'b10011; wb_req = 1'b1; wb_lreg = 4'd13; wb_data = 32'h1111_0000;
    step();
    tests++;
    if ({bank_w, bank_paddr, bank_wdata} !== {1'b1, 6'd23, 32'h1111_0000}) begin
      fails++; $display("FAIL b2b_first got w=%b a=%0d d=%h exp w=1 a=23 d=11110000", bank_w, bank_paddr, bank_wdata);
    end
    wb_lreg = 4'd3; wb_data = 32'h2222_0003;
    #1;
    tests++;
    if (wb_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack2 got %b exp 1", wb_ack); end
    step();
    wb_req = 1'b0;
    tests++;
    if ({bank_w, bank_paddr, bank_wdata} !== {1'b1, 6'd3, 32'h2222_0003}) begin
      fails++; $display("FAIL b2b_second got w=%b a=%0d d=%h exp w=1 a=3 d=22220003", bank_w, bank_paddr, bank_wdata);
    end
    step();
  endtask

  task automatic test_exc_irq;
    cur_mode = 5'b10000; cpsr_in = 32'h0000_0010; exc_type = 3'd5; exc_ret = 32'h0000_1004; exc_req = 1'b1;
    #1;
    tests++;
    if ({wb_ack, exc_ack} !== 2'b01) begin fails++; $display("FAIL irq_ack got %b exp 01", {wb_ack, exc_ack}); end
    step();
    // request left asserted: must not be re-acknowledged mid-sequence
    tests++;
    if ({ctl, bank_paddr, bank_wdata} !== {6'b100000, 6'd35, 32'h10}) begin
      fails++; $display("FAIL irq_spsr got ctl=%b a=%0d d=%h exp ctl=100000 a=35 d=10", ctl, bank_paddr, bank_wdata);
    end
    step();
    tests++;
    if ({ctl, bank_paddr, bank_wdata} !== {6'b100000, 6'd28, 32'h1004}) begin
      fails++; $display("FAIL irq_lr got ctl=%b a=%0d d=%h exp ctl=100000 a=28 d=1004", ctl, bank_paddr, bank_wdata);
    end
    step();
    exc_req = 1'b0;
    tests++;
    if ({ctl, cpsr_wdata, cpsr_mask} !== {6'b001000, 32'h92, 32'hFF}) begin
      fails++; $display("FAIL irq_cpsr got ctl=%b d=%h m=%h exp ctl=001000 d=92 m=ff", ctl, cpsr_wdata, cpsr_mask);
    end
    step();
    tests++;
    if ({ctl, pc_wdata, h_pc_wdata} !== {6'b010100, 32'h18, 32'hFFFF_0018}) begin
      fails++; $display("FAIL irq_pc got ctl=%b pc=%h hi=%h exp ctl=010100 pc=18 hi=ffff0018", ctl, pc_wdata, h_pc_wdata);
    end
    step();
    tests++;
    if (ctl !== 6'b0) begin fails++; $display("FAIL irq_after got %b exp 000000", ctl); end
  endtask

  task automatic test_exc_fiq;
    cur_mode = 5'b10000; cpsr_in = 32'h0000_0010; exc_type = 3'd6; exc_ret = 32'h0000_2000; exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    tests++;
    if ({bank_w, bank_paddr} !== {1'b1, 6'd32}) begin fails++; $display("FAIL fiq_spsr got w=%b a=%0d exp w=1 a=32", bank_w, bank_paddr); end
    step();
    tests++;
    if ({h_bank_w, h_bank_paddr, h_bank_wdata} !== {1'b1, 6'd22, 32'h2000}) begin
      fails++; $display("FAIL fiq_lr got w=%b a=%0d d=%h exp w=1 a=22 d=2000", h_bank_w, h_bank_paddr, h_bank_wdata);
    end
    step();
    tests++;
    if ({h_cpsr_w, h_cpsr_wdata} !== {1'b1, 32'hD1}) begin fails++; $display("FAIL fiq_cpsr got w=%b d=%h exp w=1 d=d1", h_cpsr_w, h_cpsr_wdata); end
    step();
    tests++;
    if ({h_pc_w, h_exc_done, h_pc_wdata, pc_wdata} !== {1'b1, 1'b1, 32'hFFFF_001C, 32'h1C}) begin
      fails++; $display("FAIL fiq_pc got w=%b done=%b hi=%h lo=%h exp w=1 done=1 hi=ffff001c lo=1c", h_pc_w, h_exc_done, h_pc_wdata, pc_wdata);
    end
    step();
  endtask

  task automatic test_wb_vs_exc;
    cur_mode = 5'b10000; cpsr_in = 32'h0000_0050;
    wb_req = 1'b1; wb_lreg = 4'd14; wb_data = 32'h0000_CAFE;
    exc_req = 1'b1; exc_type = 3'd1; exc_ret = 32'h0000_0044;
    #1;
    tests++;
    if ({wb_ack, exc_ack} !== 2'b01) begin fails++; $display("FAIL race_ack got %b exp 01", {wb_ack, exc_ack}); end
    step();
    exc_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wb_ack !== 1'b0) begin fails++; $display("FAIL race_hold[%0d] got %b exp 0", i, wb_ack); end
      if (i == 0) begin
        tests++;
        if (bank_paddr !== 6'd36) begin fails++; $display("FAIL race_spsr got %0d exp 36", bank_paddr); end
      end
      if (i == 2) begin
        tests++;  // F preserved from old CPSR for und
        if (cpsr_wdata !== 32'hDB) begin fails++; $display("FAIL race_cpsr got %h exp db", cpsr_wdata); end
      end
      step();
    end
    cur_mode = 5'b11011;
    #1;
    tests++;
    if (wb_ack !== 1'b1) begin fails++; $display("FAIL race_wb_ack got %b exp 1", wb_ack); end
    step();
    wb_req = 1'b0;
    tests++;
    if ({bank_w, bank_paddr, bank_wdata} !== {1'b1, 6'd30, 32'h0000_CAFE}) begin
      fails++; $display("FAIL race_wb got w=%b a=%0d d=%h exp w=1 a=30 d=cafe", bank_w, bank_paddr, bank_wdata);
    end
    step();
  endtask

  task automatic test_type7;
    cur_mode = 5'b10000; exc_req = 1'b1; exc_type = 3'd7;
    wb_req = 1'b1; wb_lreg = 4'd2; wb_data = 32'h7777_0002;
    #1;
    tests++;
    if ({wb_ack, exc_ack} !== 2'b10) begin fails++; $display("FAIL t7_ack got %b exp 10", {wb_ack, exc_ack}); end
    step();
    exc_req = 1'b0; wb_req = 1'b0;
    tests++;
    if ({bank_w, bank_paddr, bank_wdata} !== {1'b1, 6'd2, 32'h7777_0002}) begin
      fails++; $display("FAIL t7_wb got w=%b a=%0d d=%h exp w=1 a=2 d=77770002", bank_w, bank_paddr, bank_wdata);
    end
    step();
  endtask

  task automatic test_rst_mid;
    cur_mode = 5'b10000; cpsr_in = 32'h10; exc_type = 3'd2; exc_ret = 32'h88; exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    step();
    tests++;
    if ({bank_w, bank_paddr} !== {1'b1, 6'd24}) begin fails++; $display("FAIL rstmid_lr got w=%b a=%0d exp w=1 a=24", bank_w, bank_paddr); end
    rst = 1'b1;
    #1;
    tests++;
    if (exc_ack !== 1'b0) begin fails++; $display("FAIL rstmid_ack got %b exp 0", exc_ack); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (ctl !== 6'b0) begin fails++; $display("FAIL rstmid_quiet[%0d] got %b exp 000000", i, ctl); end
      step();
    end
    wb_req = 1'b1; wb_lreg = 4'd15; wb_data = 32'h0000_0100;
    #1;
    tests++;
    if (wb_ack !== 1'b1) begin fails++; $display("FAIL rstmid_wb_ack got %b exp 1", wb_ack); end
    step();
    wb_req = 1'b0;
    tests++;
    if ({pc_w, bank_w, pc_wdata} !== {1'b1, 1'b0, 32'h100}) begin
      fails++; $display("FAIL rstmid_pc got pc_w=%b bank_w=%b d=%h exp 1 0 100", pc_w, bank_w, pc_wdata);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; cur_mode = 5'b10000; cpsr_in = 32'h0; rd_lreg1 = 4'd0; rd_lreg2 = 4'd0;
    wb_req = 1'b0; wb_lreg = 4'd0; wb_data = 32'h0;
    exc_req = 1'b0; exc_type = 3'd0; exc_ret = 32'h0;
    test_reset();
    test_read_map();
    test_wb_irq();
    test_back_to_back();
    test_exc_irq();
    test_exc_fiq();
    test_wb_vs_exc();
    test_type7();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
- Owns the write side of the 37-entry banked register file and arbitrates its single write port between two requesters: the pipeline writeback stage and the exception-entry logic.
- Maps logical register numbers (r0-r15) plus the current processor mode to physical bank indices, for both the reads and the writes.
- On an exception, runs a multi-cycle entry sequence: save CPSR to SPSR_mode, write LR_mode, update CPSR, load PC with the vector.

Parameters:
- VECTOR_BASE, 32'h0000_0000, base address added to every exception vector offset.
- PADDR_W, 6, width of the physical bank index (37 entries).

Ports:
- clk1  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cur_mode  in  5  CPSR[4:0] from the bank.
- cpsr_in  in  32  current CPSR value.
- rd_lreg1, rd_lreg2  in  4 each  logical read register numbers.
- rd_paddr1, rd_paddr2  out  6 each  mapped physical read indices (combinational, using cur_mode).
- wb_req  in  1  writeback request.
- wb_lreg  in  4  writeback logical register.
- wb_data  in  32  writeback data.
- wb_ack  out  1  writeback accepted this edge.
- exc_req  in  1  exception request; held until exc_ack.
- exc_type  in  3  exception type: 0 reset, 1 und, 2 swi, 3 pabt, 4 dabt, 5 irq, 6 fiq, 7 reserved.
- exc_ret  in  32  return address for LR.
- exc_ack  out  1  one-cycle pulse when the exception is accepted.
- exc_done  out  1  one-cycle pulse during the PC-write cycle.
- bank_w  out  1  general write strobe.
- bank_paddr  out  6  write index.
- bank_wdata  out  32  write data.
- pc_w  out  1  PC write strobe.
- pc_wdata  out  32  PC write data.
- cpsr_w  out  1  CPSR write strobe.
- cpsr_wdata  out  32  CPSR write data.
- cpsr_mask  out  32  CPSR write mask.

Behaviour:
- Physical map:
  - r0-r7 map straight through.
  - fiq: r8-r14 map to 16-22.
  - svc: r13/r14 map to 23/24.
  - abt: r13/r14 map to 25/26.
  - irq: r13/r14 map to 27/28.
  - und: r13/r14 map to 29/30.
  - CPSR is 31. SPSR_fiq/svc/abt/irq/und are 32-36.
  - usr (10000), sys (11111) and any undefined mode encoding map identity.
  - Mode encodings: fiq 10001, irq 10010, svc 10011, abt 10111, und 11011.
- States: IDLE, WB, E_SPSR, E_LR, E_CPSR, E_PC. All strobes and write data are driven from registered state and latched operands only. wb_ack and exc_ack are the only combinational outputs.
- Reset: state IDLE. All strobes, wb_ack, exc_ack, exc_done = 0. bank_paddr, bank_wdata, pc_wdata, cpsr_wdata, cpsr_mask = 0.
- Arbitration, in IDLE or WB:
  - exc_req with exc_type != 7 wins: exc_ack=1, wb_ack=0. Latch type, exc_ret and cpsr_in; next state E_SPSR.
  - Else wb_req gives wb_ack=1. Latch the mapping (using cur_mode at the accept edge) and the data; next state WB.
  - Else next state IDLE.
- exc_type 7 is ignored: no exc_ack, and writeback proceeds.
- WB state, one cycle:
  - wb_lreg != 15: bank_w=1 at the mapped index.
  - wb_lreg == 15: pc_w=1 with pc_wdata=data instead; bank_w=0.
  - Back-to-back writebacks are accepted at one per cycle.
- Exception sequence: one cycle per state, 4 cycles total. wb_ack=0 throughout.
  - E_SPSR: bank_w=1, SPSR index of the target mode, data = latched CPSR.
  - E_LR: bank_w=1, r14 index of the target mode, data = exc_ret.
  - E_CPSR: cpsr_w=1, cpsr_mask=32'h0000_00FF.
    - cpsr_wdata[4:0] = target mode; bit 5 (T) = 0; bit 7 (I) = 1.
    - bit 6 (F) = 1 for reset/fiq, else the latched CPSR[6]; bits [31:8] = 0.
  - E_PC: pc_w=1, pc_wdata = VECTOR_BASE + offset; exc_done=1. Next state IDLE.
  - Offsets and target modes: reset 0x00 svc; und 0x04 und; swi 0x08 svc; pabt 0x0C abt; dabt 0x10 abt; irq 0x18 irq; fiq 0x1C fiq.
- exc_req asserted during a sequence is not acknowledged until the state returns to IDLE/WB. Exception requests are never queued internally.
- rst asserted mid-sequence abandons the sequence at that edge: state IDLE, no further strobes. Writes already performed are not undone.
- Simultaneous wb_req and exc_req: the exception wins and the writeback stays pending (wb_ack=0). The writeback is accepted in the E_PC cycle's following IDLE, mapped with the new mode.
- Sums are 32-bit modulo.

Test Plan:
- Reset, then idle 3 cycles -> all strobes 0, wb_ack=0, exc_ack=0.
- cur_mode=10010 (irq), wb_req with wb_lreg=13, data=32'hDEAD_BEEF -> wb_ack=1; next cycle bank_w=1, bank_paddr=27, bank_wdata=DEADBEEF.
- cur_mode=10000, cpsr_in=32'h0000_0010, exc_type=5, exc_ret=32'h0000_1004:
  - SPSR cycle: bank_w=1, bank_paddr=35, data 32'h10.
  - LR cycle: bank_paddr=28, data 32'h1004.
  - CPSR cycle: cpsr_w=1, wdata=32'h92, mask=32'hFF.
  - PC cycle: pc_w=1, pc_wdata=32'h18, exc_done=1.
- exc_type=6 with VECTOR_BASE=32'hFFFF_0000 -> LR write to paddr 22, cpsr_wdata=32'hD1, pc_wdata=32'hFFFF_001C.
- wb_req and exc_req (type 1) asserted in the same cycle -> exc_ack=1, wb_ack=0 for 4 cycles; the writeback is then accepted and mapped with und mode (r14 -> 30).
- rst asserted in the E_LR cycle -> next cycle all strobes 0, no exc_done, state IDLE; wb_lreg=15 writeback then gives pc_w=1, bank_w=0.
